// File: rtl/commit_ras_if.sv
// ============================================================================
// Module      : commit_ras_if
// Description : Bundle between the commit stage, the commit-side return
//               address stack and the speculative RAS it restores.
//               master : commit stage / restore consumer (drives commit_*)
//               slave  : commit_ras (drives restore_*, arch_count)
// Ports       : commit_valid, commit_is_call, commit_is_return,
//               commit_PC_plus_4, commit_mis_pred   (master -> slave)
//               restore_start, restore_valid, restore_addr, restore_busy,
//               restore_done, arch_count            (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface commit_ras_if #(
  parameter int XLEN    = 32,
  parameter int RAS_LEN = 2
);
  logic              commit_valid;
  logic              commit_is_call;
  logic              commit_is_return;
  logic [XLEN-1:0]   commit_PC_plus_4;
  logic              commit_mis_pred;
  logic              restore_start;
  logic              restore_valid;
  logic [XLEN-1:0]   restore_addr;
  logic              restore_busy;
  logic              restore_done;
  logic [RAS_LEN:0]  arch_count;

  modport master (
    output commit_valid, commit_is_call, commit_is_return,
           commit_PC_plus_4, commit_mis_pred,
    input  restore_start, restore_valid, restore_addr,
           restore_busy, restore_done, arch_count
  );

  modport slave (
    input  commit_valid, commit_is_call, commit_is_return,
           commit_PC_plus_4, commit_mis_pred,
    output restore_start, restore_valid, restore_addr,
           restore_busy, restore_done, arch_count
  );
endinterface

`default_nettype wire

// File: rtl/commit_ras.sv
// ============================================================================
// Module      : commit_ras
// Description : Commit-side return address stack. Retired calls push and
//               retired returns pop, so the stack holds the architectural
//               call chain. On a committed mispredict the entries are
//               streamed oldest-first to the speculative RAS as push beats.
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-low reset
//               bus    - commit_ras_if.slave (commit inputs, restore outputs,
//                        arch_count)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_ras #(
  parameter int XLEN     = 32,
  parameter int RAS_SIZE = 4,
  parameter int RAS_LEN  = 2
) (
  input  wire logic        clock,
  input  wire logic        reset,
  commit_ras_if.slave      bus
);

  localparam logic [RAS_LEN:0] C_FULL = (RAS_LEN+1)'(RAS_SIZE);
  localparam logic [RAS_LEN:0] C_ONE  = (RAS_LEN+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_stk [RAS_SIZE];
  logic [RAS_LEN-1:0]  r_tosp;
  logic [RAS_LEN:0]    r_count;
  logic [RAS_LEN-1:0]  r_rd_idx;   // slot of the beat presented this cycle
  logic [RAS_LEN:0]    r_n;        // beats remaining, including the current one
  logic                r_start;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;

  // --------------------------------------------------------------------------
  // Commit decode
  // --------------------------------------------------------------------------
  logic w_call, w_ret, w_empty;
  logic w_push, w_replace, w_pop, w_modify, w_wr_en, w_snap;
  logic [RAS_LEN-1:0] w_wr_idx, w_tosp_nxt, w_snap_idx;
  logic [RAS_LEN:0]   w_count_nxt;

  assign w_call    = bus.commit_valid & bus.commit_is_call;
  assign w_ret     = bus.commit_valid & bus.commit_is_return;
  assign w_empty   = (r_count == '0);
  // A coroutine jalr on an empty stack degenerates to a plain push.
  assign w_push    = w_call & (~w_ret | w_empty);
  assign w_replace = w_call & w_ret & ~w_empty;
  assign w_pop     = w_ret & ~w_call & ~w_empty;
  assign w_modify  = w_push | w_replace | w_pop;
  assign w_wr_en   = w_push | w_replace;
  assign w_wr_idx  = w_push ? r_tosp + 1'b1 : r_tosp;

  always_comb begin
    w_tosp_nxt  = r_tosp;
    w_count_nxt = r_count;
    if (w_push) begin
      w_tosp_nxt = r_tosp + 1'b1;
      if (r_count != C_FULL) w_count_nxt = r_count + 1'b1;
    end else if (w_pop) begin
      w_tosp_nxt  = r_tosp - 1'b1;
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Oldest entry of the post-commit stack. When full the low bits of the
  // count are zero, so this lands on tosp+1, the slot about to be overwritten.
  assign w_snap_idx = w_tosp_nxt - w_count_nxt[RAS_LEN-1:0] + 1'b1;

  // Any stack-modifying commit during a restore restarts it, since the
  // speculative RAS is cleared again by the new restore_start.
  assign w_snap = bus.commit_valid &
                  (bus.commit_mis_pred | ((r_state != S_IDLE) & w_modify));

  // --------------------------------------------------------------------------
  // Architectural stack
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_SIZE; i++) r_stk[i] <= '0;
      r_tosp  <= RAS_LEN'(RAS_SIZE - 1);
      r_count <= '0;
    end else begin
      if (w_wr_en) r_stk[w_wr_idx] <= bus.commit_PC_plus_4;
      r_tosp  <= w_tosp_nxt;
      r_count <= w_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Restore FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rd_idx <= '0;
      r_n      <= '0;
      r_start  <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (w_snap) begin
      r_state  <= S_COPY;
      r_rd_idx <= w_snap_idx;
      r_n      <= w_count_nxt;
      r_start  <= 1'b1;
      r_valid  <= (w_count_nxt != '0);
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_COPY: begin
          if (r_n <= C_ONE) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_n      <= r_n - 1'b1;
            r_rd_idx <= r_rd_idx + 1'b1;
            r_valid  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The beat data is read from the registered index; any commit that would
  // change the slot being read also restarts the stream.
  assign bus.restore_start = r_start;
  assign bus.restore_valid = r_valid;
  assign bus.restore_addr  = r_valid ? r_stk[r_rd_idx] : '0;
  assign bus.restore_busy  = r_busy;
  assign bus.restore_done  = r_done;
  assign bus.arch_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_commit_ras.sv
// ============================================================================
// Module      : tb_commit_ras
// Description : Self-checking bench for commit_ras. A driver applies directed
//               and random commits, updates a queue-based reference stack and
//               pushes the expected per-cycle restore outputs into a
//               scoreboard; a monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_ras;
  localparam int XLEN     = 32;
  localparam int RAS_SIZE = 4;
  localparam int RAS_LEN  = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  commit_ras_if #(.XLEN(XLEN), .RAS_LEN(RAS_LEN)) bus ();

  commit_ras #(.XLEN(XLEN), .RAS_SIZE(RAS_SIZE), .RAS_LEN(RAS_LEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] addr;
    logic        done;
    logic        busy;
    logic [2:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] mstk[$];      // reference stack, oldest at index 0
  logic [31:0] plan[$];      // beats still owed to the speculative RAS
  bit          m_active = 0;
  bit          m_first  = 0;
  bit          cur_busy = 0;
  bit          rst_drv  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // One clock cycle of stimulus plus the reference model's prediction of the
  // outputs visible after the coming edge.
  task automatic step(input bit v, input bit call, input bit ret,
                      input logic [31:0] pc, input bit mp);
    exp_t e;
    bit   modified, snap;
    @(negedge clock);
    reset                = rst_drv;
    bus.commit_valid     = v;
    bus.commit_is_call   = call;
    bus.commit_is_return = ret;
    bus.commit_PC_plus_4 = pc;
    bus.commit_mis_pred  = mp;
    e.start = 0; e.valid = 0; e.addr = '0; e.done = 0; e.busy = 0;
    if (!rst_drv) begin
      mstk.delete(); plan.delete(); m_active = 0; m_first = 0;
    end else begin
      modified = v && (call || (ret && mstk.size() > 0));
      if (v) begin
        if (call && (!ret || mstk.size() == 0)) begin
          mstk.push_back(pc);
          if (mstk.size() > RAS_SIZE) void'(mstk.pop_front());
        end else if (call && ret) begin
          mstk[mstk.size()-1] = pc;
        end else if (ret && mstk.size() > 0) begin
          void'(mstk.pop_back());
        end
      end
      snap = v && (mp || (cur_busy && modified));
      if (snap) begin
        plan = mstk; m_active = 1; m_first = 1;
      end
      if (m_active) begin
        e.busy = 1;
        if (m_first) begin
          e.start = 1; m_first = 0;
          if (plan.size() > 0) begin e.valid = 1; e.addr = plan.pop_front(); end
        end else if (plan.size() > 0) begin
          e.valid = 1; e.addr = plan.pop_front();
        end else begin
          e.done = 1; m_active = 0;
        end
      end
    end
    e.cnt    = 3'(mstk.size());
    cur_busy = e.busy;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2;
    chk("valid_before_reset", {31'b0, bus.restore_valid}, 32'd1);
    reset = 1'b0; rst_drv = 0; bus.commit_valid = 0;
    #1;
    chk("rst_start", {31'b0, bus.restore_start}, 32'd0);
    chk("rst_valid", {31'b0, bus.restore_valid}, 32'd0);
    chk("rst_addr",  bus.restore_addr, 32'd0);
    chk("rst_busy",  {31'b0, bus.restore_busy}, 32'd0);
    chk("rst_done",  {31'b0, bus.restore_done}, 32'd0);
    chk("rst_count", {29'b0, bus.arch_count}, 32'd0);
    mstk.delete(); plan.delete(); m_active = 0; m_first = 0; cur_busy = 0;
  endtask

  // Monitor: compares the DUT against the oldest scoreboard entry after each edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("restore_start", {31'b0, bus.restore_start}, {31'b0, e.start});
      chk("restore_valid", {31'b0, bus.restore_valid}, {31'b0, e.valid});
      if (e.valid) chk("restore_addr", bus.restore_addr, e.addr);
      chk("restore_done",  {31'b0, bus.restore_done},  {31'b0, e.done});
      chk("restore_busy",  {31'b0, bus.restore_busy},  {31'b0, e.busy});
      chk("arch_count",    {29'b0, bus.arch_count},    {29'b0, e.cnt});
    end
  end

  initial begin
    bit v, c, r, m;
    bus.commit_valid = 0; bus.commit_is_call = 0; bus.commit_is_return = 0;
    bus.commit_PC_plus_4 = '0; bus.commit_mis_pred = 0;
    rst_drv = 0;
    idle(3);
    rst_drv = 1;

    // Push/pop and underflow
    step(1, 1, 0, 32'h100, 0);
    step(1, 1, 0, 32'h200, 0);
    step(1, 0, 1, 32'h0, 0);
    step(1, 0, 1, 32'h0, 0);
    step(1, 0, 1, 32'h0, 0);
    idle(2);

    // Overflow wrap then restore
    for (int i = 1; i <= 6; i++) step(1, 1, 0, 32'(i * 16), 0);
    step(1, 0, 0, 32'h0, 1);
    idle(7);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'h0, 0);

    // Mispredicting call is applied before the snapshot
    step(1, 1, 0, 32'h100, 0);
    step(1, 1, 0, 32'h200, 0);
    step(1, 1, 0, 32'h300, 1);
    idle(5);

    // Empty restore
    for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h0, 0);
    step(1, 0, 0, 32'h0, 1);
    idle(4);

    // Restart mid-copy: return during the second beat
    step(1, 1, 0, 32'hA0, 0);
    step(1, 1, 0, 32'hB0, 0);
    step(1, 1, 0, 32'hC0, 0);
    step(1, 0, 0, 32'h0, 1);
    idle(1);
    step(1, 0, 1, 32'h0, 0);
    idle(6);

    // Coroutine replace, then restore interrupted by async reset
    step(1, 1, 1, 32'h700, 0);
    step(1, 0, 0, 32'h0, 1);
    idle(1);
    async_reset();
    idle(2);
    rst_drv = 1;
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 70);
      c = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 19) == 0);
      step(v, c, r, $urandom & 32'hFFFF_FFFC, m);
    end
    idle(10);

    @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
